fdiv_core: RTL and testbench

- Sequential IEEE-754 binary32 floating-point divider: result = a / b.
- Iterative radix-2 restoring mantissa division with fixed latency.
- Round-to-nearest-even; denormals flushed to zero.
- Used as a multi-cycle arithmetic unit behind a start/done handshake.

---
 rtl/fp32_pkg.sv | 40 ++++
 rtl/fdiv_core_if.sv | 15 +
 rtl/fp32_round_pack.sv | 70 +++++++
 rtl/fdiv_core.sv | 124 ++++++++++++
 tb/tb_fdiv_core.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fp32_pkg.sv
// Shared binary32 types, constants and operand classification for the
// sequential divider.
package fp32_pkg;

    localparam logic [31:0] QNAN       = 32'h7FC00000;
    localparam int          EXP_BIAS   = 127;
    localparam int          MANT_W     = 23;
    localparam int          EXP_W      = 8;
    localparam int          LATENCY    = 28;
    localparam int          DIV_CYCLES = LATENCY - 2;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] frac;
    } fp32_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UNPACK = 2'd1,
        DIV    = 2'd2,
        ROUND  = 2'd3
    } state_t;

    typedef struct packed {
        logic is_zero;
        logic is_inf;
        logic is_nan;
    } fp_class_t;

    // A zero exponent field counts as zero, so input denormals flush here.
    function automatic fp_class_t classify(input fp32_t x);
        fp_class_t c;
        c.is_zero = (x.exp == '0);
        c.is_inf  = (x.exp == '1) && (x.frac == '0);
        c.is_nan  = (x.exp == '1) && (x.frac != '0);
        return c;
    endfunction

endpackage

// File: rtl/fdiv_core_if.sv
// Start/done handshake bundle between the divider and its requester.
// start is sampled only while busy=0; done is a one-cycle pulse after which
// result/flags stay valid until the next done or reset.
interface fdiv_core_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  flags;

    modport master (output start, a, b, input busy, done, result, flags);
    modport slave  (input start, a, b, output busy, done, result, flags);
endinterface

// File: rtl/fp32_round_pack.sv
// Combinational back end: normalise the raw quotient, round to nearest even,
// select special-case results and pack binary32 plus exception flags.
module fp32_round_pack
    import fp32_pkg::*;
(
    input  logic              i_sign,
    input  logic signed [9:0] i_exp,
    input  logic [25:0]       i_quot,
    input  logic              i_rem_nz,
    input  fp_class_t         i_cls_a,
    input  fp_class_t         i_cls_b,
    output logic [31:0]       o_result,
    output logic [4:0]        o_flags
);

    logic [25:0]       w_norm_q;
    logic signed [9:0] w_exp0;
    logic [23:0]       w_mant;
    logic              w_guard;
    logic              w_sticky;
    logic              w_rnd_up;
    logic [24:0]       w_mant_r;
    logic              w_carry;
    logic [22:0]       w_frac;
    logic signed [9:0] w_exp_f;
    fp32_t             w_pack;

    assign w_norm_q = i_quot[25] ? i_quot : {i_quot[24:0], 1'b0};
    assign w_exp0   = i_quot[25] ? i_exp : i_exp - 10'sd1;
    assign w_mant   = w_norm_q[25:2];
    assign w_guard  = w_norm_q[1];
    assign w_sticky = w_norm_q[0] | i_rem_nz;
    assign w_rnd_up = w_guard & (w_sticky | w_mant[0]);
    assign w_mant_r = {1'b0, w_mant} + {24'd0, w_rnd_up};
    // A carry out of rounding leaves mantissa 1.000..., one binade up.
    assign w_carry  = w_mant_r[24];
    assign w_frac   = w_carry ? w_mant_r[23:1] : w_mant_r[22:0];
    assign w_exp_f  = w_exp0 + (w_carry ? 10'sd1 : 10'sd0);
    assign w_pack   = '{sign: i_sign, exp: w_exp_f[7:0], frac: w_frac};

    always_comb begin
        o_result = 32'd0;
        o_flags  = 5'd0;
        if (i_cls_a.is_nan || i_cls_b.is_nan ||
            (i_cls_a.is_zero && i_cls_b.is_zero) ||
            (i_cls_a.is_inf && i_cls_b.is_inf)) begin
            o_result = QNAN;
            o_flags  = 5'b10000;
        end else if (i_cls_a.is_inf) begin
            o_result = {i_sign, 8'hFF, 23'd0};
        end else if (i_cls_b.is_inf) begin
            o_result = {i_sign, 31'd0};
        end else if (i_cls_b.is_zero) begin
            o_result = {i_sign, 8'hFF, 23'd0};
            o_flags  = 5'b01000;
        end else if (i_cls_a.is_zero) begin
            o_result = {i_sign, 31'd0};
        end else if (w_exp_f >= 10'sd255) begin
            o_result = {i_sign, 8'hFF, 23'd0};
            o_flags  = 5'b00101;
        end else if (w_exp_f <= 10'sd0) begin
            o_result = {i_sign, 31'd0};
            o_flags  = 5'b00011;
        end else begin
            o_result = w_pack;
            o_flags  = {4'b0000, w_guard | w_sticky};
        end
    end

endmodule

// File: rtl/fdiv_core.sv
// Fixed-latency binary32 divider: one unpack cycle, 26 restoring iterations,
// one round/pack cycle, then a done pulse.
module fdiv_core
    import fp32_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    fdiv_core_if.slave bus,
    output state_t    o_dbg_state
);

    state_t            r_state;
    state_t            w_next_state;
    fp32_t             r_a;
    fp32_t             r_b;
    logic              r_sign;
    logic signed [9:0] r_exp;
    fp_class_t         r_cls_a;
    fp_class_t         r_cls_b;
    logic [23:0]       r_mb;
    logic [24:0]       r_rem;
    logic [25:0]       r_quot;
    logic [4:0]        r_cnt;
    logic              r_done;
    logic [31:0]       r_result;
    logic [4:0]        r_flags;

    logic              w_ge;
    logic [24:0]       w_sub;
    logic [24:0]       w_sel;
    logic [31:0]       w_pack_result;
    logic [4:0]        w_pack_flags;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next_state = UNPACK;
            UNPACK:  w_next_state = DIV;
            DIV:     if (r_cnt == 5'(DIV_CYCLES - 1)) w_next_state = ROUND;
            ROUND:   w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.busy    = (r_state != IDLE);
        o_dbg_state = r_state;
    end

    // Partial remainder stays below 2*mb, so 25 bits hold it between steps.
    assign w_ge  = (r_rem >= {1'b0, r_mb});
    assign w_sub = r_rem - {1'b0, r_mb};
    assign w_sel = w_ge ? w_sub : r_rem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_sign   <= 1'b0;
            r_exp    <= '0;
            r_cls_a  <= '0;
            r_cls_b  <= '0;
            r_mb     <= '0;
            r_rem    <= '0;
            r_quot   <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_flags  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_a <= bus.a;
                        r_b <= bus.b;
                    end
                end
                UNPACK: begin
                    r_sign  <= r_a.sign ^ r_b.sign;
                    r_exp   <= 10'(r_a.exp) - 10'(r_b.exp) + 10'(EXP_BIAS);
                    r_cls_a <= classify(r_a);
                    r_cls_b <= classify(r_b);
                    r_mb    <= {1'b1, r_b.frac};
                    r_rem   <= {2'b01, r_a.frac};
                    r_quot  <= '0;
                    r_cnt   <= '0;
                end
                DIV: begin
                    r_quot <= {r_quot[24:0], w_ge};
                    r_rem  <= w_sel << 1;
                    r_cnt  <= r_cnt + 5'd1;
                end
                ROUND: begin
                    r_result <= w_pack_result;
                    r_flags  <= w_pack_flags;
                    r_done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    fp32_round_pack u_round_pack (
        .i_sign   (r_sign),
        .i_exp    (r_exp),
        .i_quot   (r_quot),
        .i_rem_nz (|r_rem),
        .i_cls_a  (r_cls_a),
        .i_cls_b  (r_cls_b),
        .o_result (w_pack_result),
        .o_flags  (w_pack_flags)
    );

    assign bus.done   = r_done;
    assign bus.result = r_result;
    assign bus.flags  = r_flags;

endmodule

// File: tb/tb_fdiv_core.sv
// Directed-vector bench for fdiv_core: arithmetic, exceptions, range limits
// and handshake control, with hand-computed expected values.
module tb_fdiv_core;
    import fp32_pkg::*;

    logic   clk;
    logic   rst;
    state_t dbg_state;
    int     n_cmp;
    int     n_err;

    fdiv_core_if bus();

    fdiv_core dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb,
                          input logic [31:0] er, input logic [4:0] ef,
                          input string nm);
        int cyc;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.a     = ta;
        bus.b     = tb;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL %s busy_after_start: got %b expected 1", nm, bus.busy);
        end
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_cmp++;
        if (cyc != LATENCY) begin
            n_err++;
            $display("FAIL %s latency: got %0d expected %0d", nm, cyc, LATENCY);
        end
        n_cmp++;
        if (bus.result !== er) begin
            n_err++;
            $display("FAIL %s result: got %h expected %h", nm, bus.result, er);
        end
        n_cmp++;
        if (bus.flags !== ef) begin
            n_err++;
            $display("FAIL %s flags: got %b expected %b", nm, bus.flags, ef);
        end
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s busy_at_done: got %b expected 0", nm, bus.busy);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (bus.done !== 1'b0 || bus.result !== er) begin
            n_err++;
            $display("FAIL %s done_pulse_hold: got done=%b result=%h expected done=0 result=%h",
                     nm, bus.done, bus.result, er);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'd0 ||
            bus.flags !== 5'd0 || dbg_state !== IDLE) begin
            n_err++;
            $display("FAIL reset_state: got busy=%b done=%b result=%h flags=%b state=%0d expected all zero",
                     bus.busy, bus.done, bus.result, bus.flags, dbg_state);
        end
        rst = 1'b0;
    endtask

    task automatic test_arith();
        run_op(32'h41280000, 32'h40A00000, 32'h40066666, 5'b00001, "10.5/5");
        run_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, "1/3");
        run_op(32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, "6/2");
        run_op(32'hBFC00000, 32'h3F000000, 32'hC0400000, 5'b00000, "-1.5/0.5");
        run_op(32'h40000000, 32'h40400000, 32'h3F2AAAAB, 5'b00001, "2/3");
    endtask

    task automatic test_special();
        run_op(32'hC0000000, 32'h00000000, 32'hFF800000, 5'b01000, "-2/0");
        run_op(32'h00000000, 32'h00000000, 32'h7FC00000, 5'b10000, "0/0");
        run_op(32'h7F800000, 32'hFF800000, 32'h7FC00000, 5'b10000, "inf/-inf");
        run_op(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 5'b10000, "nan/1");
        run_op(32'h7F800000, 32'h40000000, 32'h7F800000, 5'b00000, "inf/2");
        run_op(32'hC0000000, 32'h7F800000, 32'h80000000, 5'b00000, "-2/inf");
        run_op(32'h00000001, 32'h3F800000, 32'h00000000, 5'b00000, "denorm/1");
    endtask

    task automatic test_range();
        run_op(32'h7F000000, 32'h3E800000, 32'h7F800000, 5'b00101, "overflow");
        run_op(32'h00800000, 32'h40000000, 32'h00000000, 5'b00011, "underflow");
    endtask

    task automatic test_busy_ignore();
        int cyc;
        int extra;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.a     = 32'h40C00000;
        bus.b     = 32'h40000000;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 0;
        repeat (5) begin
            @(posedge clk); #1;
            cyc++;
        end
        bus.start = 1'b1;
        bus.a     = 32'h3F800000;
        bus.b     = 32'h40400000;
        @(posedge clk); #1;
        cyc++;
        bus.start = 1'b0;
        while (bus.done !== 1'b1 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_cmp++;
        if (cyc != LATENCY || bus.result !== 32'h40400000) begin
            n_err++;
            $display("FAIL busy_ignore_first: got cyc=%0d result=%h expected cyc=%0d result=40400000",
                     cyc, bus.result, LATENCY);
        end
        extra = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) extra++;
        end
        n_cmp++;
        if (extra != 0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL busy_ignore_single_done: got extra_done=%0d busy=%b expected 0 and 0",
                     extra, bus.busy);
        end
    endtask

    task automatic test_reset_abort();
        int seen;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.a     = 32'h41280000;
        bus.b     = 32'h40A00000;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'd0 ||
            bus.flags !== 5'd0 || dbg_state !== IDLE) begin
            n_err++;
            $display("FAIL reset_abort_state: got busy=%b done=%b result=%h flags=%b expected zeros",
                     bus.busy, bus.done, bus.result, bus.flags);
        end
        @(posedge clk); #1;
        rst  = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) seen++;
        end
        n_cmp++;
        if (seen != 0 || bus.result !== 32'd0) begin
            n_err++;
            $display("FAIL reset_abort_no_done: got done_count=%0d result=%h expected 0 and 00000000",
                     seen, bus.result);
        end
        run_op(32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, "after_reset");
    endtask

    task automatic test_back_to_back();
        int cyc;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.a     = 32'h3F800000;
        bus.b     = 32'h40400000;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_cmp++;
        if (cyc != LATENCY || bus.result !== 32'h3EAAAAAB) begin
            n_err++;
            $display("FAIL b2b_first: got cyc=%0d result=%h expected cyc=%0d result=3eaaaaab",
                     cyc, bus.result, LATENCY);
        end
        bus.start = 1'b1;
        bus.a     = 32'hC0000000;
        bus.b     = 32'h3E800000;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_accept: got busy=%b done=%b expected busy=1 done=0",
                     bus.busy, bus.done);
        end
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_cmp++;
        if (cyc != LATENCY || bus.result !== 32'hC1000000 || bus.flags !== 5'b00000) begin
            n_err++;
            $display("FAIL b2b_second: got cyc=%0d result=%h flags=%b expected cyc=%0d result=c1000000 flags=00000",
                     cyc, bus.result, bus.flags, LATENCY);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_arith();
        test_special();
        test_range();
        test_busy_ignore();
        test_reset_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
